// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters ps2c, deserialises 11-bit frames and
// reports a checked byte, a parity error or a framing/timeout error as one-cycle ticks.
module ps2_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 100000,
  parameter int unsigned TO_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       rx_idle,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       parity_err_tick,
  output logic       frame_err_tick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  fval_q, fval_d;
  logic                  dsync1_q, dsync2_q;
  logic [3:0]            n_q, n_d;
  logic [10:0]           b_q, b_d;
  logic [TO_W-1:0]       to_q, to_d, to_inc;
  logic [7:0]            dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  fall_edge;
  logic                  par_ok, stop_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      filter_q <= '1;
      fval_q   <= 1'b1;
      dsync1_q <= 1'b1;
      dsync2_q <= 1'b1;
      n_q      <= '0;
      b_q      <= '0;
      to_q     <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      fval_q   <= fval_d;
      dsync1_q <= ps2d;
      dsync2_q <= dsync1_q;
      n_q      <= n_d;
      b_q      <= b_d;
      to_q     <= to_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  // Level only moves once the whole window agrees, so short glitches never reach the FSM.
  always_comb begin
    filter_d = {ps2c, filter_q[FILTER_LEN-1:1]};
    fval_d   = fval_q;
    if (&filter_d) begin
      fval_d = 1'b1;
    end else if (~|filter_d) begin
      fval_d = 1'b0;
    end
  end

  assign fall_edge = fval_q & ~fval_d;
  assign to_inc    = to_q + 1'b1;
  assign par_ok    = ^b_q[9:1];
  assign stop_ok   = b_q[10];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    to_d    = to_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_edge && rx_en && !dsync2_q) begin
          b_d     = {dsync2_q, b_q[10:1]};
          n_d     = 4'd9;
          to_d    = '0;
          state_d = ST_DPS;
        end
      end
      ST_DPS: begin
        if (fall_edge) begin
          b_d  = {dsync2_q, b_q[10:1]};
          to_d = '0;
          if (n_q == 4'd0) begin
            state_d = ST_LOAD;
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (to_inc == TO_LAST) begin
          // Device stalled mid-frame: drop the partial frame.
          ferr_d  = 1'b1;
          to_d    = '0;
          state_d = ST_IDLE;
        end else begin
          to_d = to_inc;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        if (par_ok && stop_ok) begin
          dout_d = b_q[8:1];
          done_d = 1'b1;
        end
        perr_d = ~par_ok;
        ferr_d = ~stop_ok;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_idle         = (state_q == ST_IDLE);
  assign rx_done_tick    = done_q;
  assign dout            = dout_q;
  assign parity_err_tick = perr_q;
  assign frame_err_tick  = ferr_q;

endmodule
